// File: rtl/jtag_tap_ctrl_pkg.sv
// Shared JTAG TAP constants: IR width, opcodes and 1149.1 state encodings.
// Imported by the controller, its FSM and the bench.
package jtag_tap_ctrl_pkg;

  localparam int IR_LENGTH = 4;

  localparam logic [IR_LENGTH-1:0] EXTEST = 4'h0;
  localparam logic [IR_LENGTH-1:0] SCAN_N = 4'h1;
  localparam logic [IR_LENGTH-1:0] IDCODE = 4'h2;
  localparam logic [IR_LENGTH-1:0] BYPASS = 4'hF;

  typedef enum logic [3:0] {
    TAP_EXIT2_DR  = 4'h0,
    TAP_EXIT1_DR  = 4'h1,
    TAP_SHIFT_DR  = 4'h2,
    TAP_PAUSE_DR  = 4'h3,
    TAP_SEL_IR    = 4'h4,
    TAP_UPDATE_DR = 4'h5,
    TAP_CAPT_DR   = 4'h6,
    TAP_SEL_DR    = 4'h7,
    TAP_EXIT2_IR  = 4'h8,
    TAP_EXIT1_IR  = 4'h9,
    TAP_SHIFT_IR  = 4'hA,
    TAP_PAUSE_IR  = 4'hB,
    TAP_RTI       = 4'hC,
    TAP_UPDATE_IR = 4'hD,
    TAP_CAPT_IR   = 4'hE,
    TAP_TLR       = 4'hF
  } tap_state_t;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state 1149.1 TAP state machine with registered state decodes.
// state_nxt is exposed so the IR can load IDCODE on entry to TLR.
module jtag_tap_fsm
  import jtag_tap_ctrl_pkg::*;
(
  input  logic       tck,
  input  logic       reset_,
  input  logic       tms,
  output tap_state_t state,
  output tap_state_t state_nxt,
  output logic       test_logic_reset,
  output logic       run_test_idle,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir
);

  always_comb begin
    state_nxt = TAP_TLR;
    unique case (state)
      TAP_TLR:       state_nxt = tms ? TAP_TLR      : TAP_RTI;
      TAP_RTI:       state_nxt = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_DR:    state_nxt = tms ? TAP_SEL_IR   : TAP_CAPT_DR;
      TAP_CAPT_DR:   state_nxt = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_SHIFT_DR:  state_nxt = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_EXIT1_DR:  state_nxt = tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR:  state_nxt = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
      TAP_EXIT2_DR:  state_nxt = tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
      TAP_UPDATE_DR: state_nxt = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_IR:    state_nxt = tms ? TAP_TLR      : TAP_CAPT_IR;
      TAP_CAPT_IR:   state_nxt = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_SHIFT_IR:  state_nxt = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_EXIT1_IR:  state_nxt = tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR:  state_nxt = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
      TAP_EXIT2_IR:  state_nxt = tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
      TAP_UPDATE_IR: state_nxt = tms ? TAP_SEL_DR   : TAP_RTI;
      default:       state_nxt = TAP_TLR;
    endcase
  end

  // Decodes are registered from state_nxt so they track state exactly.
  always_ff @(posedge tck) begin
    if (!reset_) begin
      state            <= TAP_TLR;
      test_logic_reset <= 1'b1;
      run_test_idle    <= 1'b0;
      capture_dr       <= 1'b0;
      shift_dr         <= 1'b0;
      update_dr        <= 1'b0;
      capture_ir       <= 1'b0;
      shift_ir         <= 1'b0;
      update_ir        <= 1'b0;
    end else begin
      state            <= state_nxt;
      test_logic_reset <= (state_nxt == TAP_TLR);
      run_test_idle    <= (state_nxt == TAP_RTI);
      capture_dr       <= (state_nxt == TAP_CAPT_DR);
      shift_dr         <= (state_nxt == TAP_SHIFT_DR);
      update_dr        <= (state_nxt == TAP_UPDATE_DR);
      capture_ir       <= (state_nxt == TAP_CAPT_IR);
      shift_ir         <= (state_nxt == TAP_SHIFT_IR);
      update_ir        <= (state_nxt == TAP_UPDATE_IR);
    end
  end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller: IR, BYPASS and IDCODE registers plus TDO retiming.
// DR strobes go downstream for every instruction; ir qualifies them there.
module jtag_tap_ctrl
  import jtag_tap_ctrl_pkg::*;
#(
  parameter int          IR_BITS      = IR_LENGTH,
  parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001
) (
  input  logic               tck,
  input  logic               reset_,
  input  logic               tms,
  input  logic               tdi,
  output logic               tdo,
  output logic               tdo_oe,
  input  logic               tdo_i,
  output logic [IR_BITS-1:0] ir,
  output logic               capture_dr,
  output logic               shift_dr,
  output logic               update_dr,
  output logic               test_logic_reset,
  output logic               run_test_idle
);

  localparam logic [IR_BITS-1:0] OP_IDCODE = IR_BITS'(IDCODE);
  localparam logic [IR_BITS-1:0] OP_EXTEST = IR_BITS'(EXTEST);
  localparam logic [IR_BITS-1:0] OP_SCAN_N = IR_BITS'(SCAN_N);
  localparam logic [IR_BITS-1:0] IR_CAPT   = IR_BITS'(2'b01);
  localparam logic [31:0]        ID_CAPT   = {IDCODE_VALUE[31:1], 1'b1};

  tap_state_t         state;
  tap_state_t         state_nxt;
  logic               capture_ir;
  logic               shift_ir;
  logic               update_ir;
  logic [IR_BITS-1:0] ir_sr;
  logic               bypass_q;
  logic [31:0]        idcode_sr;
  logic               rst_seen_n;
  logic               sel_id;
  logic               sel_ext;
  logic               tdo_nxt;

  jtag_tap_fsm u_fsm (
    .tck              (tck),
    .reset_           (reset_),
    .tms              (tms),
    .state            (state),
    .state_nxt        (state_nxt),
    .test_logic_reset (test_logic_reset),
    .run_test_idle    (run_test_idle),
    .capture_dr       (capture_dr),
    .shift_dr         (shift_dr),
    .update_dr        (update_dr),
    .capture_ir       (capture_ir),
    .shift_ir         (shift_ir),
    .update_ir        (update_ir)
  );

  always_ff @(posedge tck) begin
    if (!reset_) begin
      ir        <= OP_IDCODE;
      ir_sr     <= '0;
      bypass_q  <= 1'b0;
      idcode_sr <= ID_CAPT;
    end else begin
      if (capture_ir)
        ir_sr <= IR_CAPT;
      else if (shift_ir)
        ir_sr <= {tdi, ir_sr[IR_BITS-1:1]};
      if (state_nxt == TAP_TLR)
        ir <= OP_IDCODE;
      else if (update_ir)
        ir <= ir_sr;
      if (capture_dr) begin
        bypass_q  <= 1'b0;
        idcode_sr <= ID_CAPT;
      end else if (shift_dr) begin
        bypass_q  <= tdi;
        idcode_sr <= {tdi, idcode_sr[31:1]};
      end
    end
  end

  assign sel_id  = (ir == OP_IDCODE);
  assign sel_ext = (ir == OP_EXTEST) || (ir == OP_SCAN_N);

  always_comb begin
    tdo_nxt = 1'b0;
    unique case (1'b1)
      shift_ir:                       tdo_nxt = ir_sr[0];
      shift_dr && sel_id:             tdo_nxt = idcode_sr[0];
      shift_dr && sel_ext:            tdo_nxt = tdo_i;
      shift_dr && !sel_id && !sel_ext: tdo_nxt = bypass_q;
      default:                        tdo_nxt = 1'b0;
    endcase
  end

  // Lets the falling-edge flops see a reset taken on the previous rising edge.
  always_ff @(posedge tck) begin
    rst_seen_n <= reset_;
  end

  always_ff @(negedge tck) begin
    if (!rst_seen_n) begin
      tdo    <= 1'b0;
      tdo_oe <= 1'b0;
    end else begin
      tdo    <= tdo_nxt;
      tdo_oe <= shift_ir | shift_dr;
    end
  end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Bench for jtag_tap_ctrl: queue-based TAP model checked every cycle,
// plus directed scans with hand-computed results.
module tb_jtag_tap_ctrl;
  import jtag_tap_ctrl_pkg::*;

  localparam logic [31:0] IDV = 32'h1000_0001;

  logic tck = 1'b0;
  logic reset_ = 1'b0;
  logic tms = 1'b1;
  logic tdi = 1'b0;
  logic tdo_i = 1'b0;
  logic tdo, tdo_oe;
  logic [IR_LENGTH-1:0] ir;
  logic capture_dr, shift_dr, update_dr;
  logic test_logic_reset, run_test_idle;

  jtag_tap_ctrl #(.IR_BITS(IR_LENGTH), .IDCODE_VALUE(IDV)) dut (
    .tck              (tck),
    .reset_           (reset_),
    .tms              (tms),
    .tdi              (tdi),
    .tdo              (tdo),
    .tdo_oe           (tdo_oe),
    .tdo_i            (tdo_i),
    .ir               (ir),
    .capture_dr       (capture_dr),
    .shift_dr         (shift_dr),
    .update_dr        (update_dr),
    .test_logic_reset (test_logic_reset),
    .run_test_idle    (run_test_idle)
  );

  always #5 tck = ~tck;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 0;
  int cnt_cap = 0, cnt_shift = 0, cnt_upd = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transition table: [state][tms]
  tap_state_t tbl [0:15][0:1];
  initial begin
    tbl[TAP_TLR]       = '{TAP_RTI,       TAP_TLR};
    tbl[TAP_RTI]       = '{TAP_RTI,       TAP_SEL_DR};
    tbl[TAP_SEL_DR]    = '{TAP_CAPT_DR,   TAP_SEL_IR};
    tbl[TAP_CAPT_DR]   = '{TAP_SHIFT_DR,  TAP_EXIT1_DR};
    tbl[TAP_SHIFT_DR]  = '{TAP_SHIFT_DR,  TAP_EXIT1_DR};
    tbl[TAP_EXIT1_DR]  = '{TAP_PAUSE_DR,  TAP_UPDATE_DR};
    tbl[TAP_PAUSE_DR]  = '{TAP_PAUSE_DR,  TAP_EXIT2_DR};
    tbl[TAP_EXIT2_DR]  = '{TAP_SHIFT_DR,  TAP_UPDATE_DR};
    tbl[TAP_UPDATE_DR] = '{TAP_RTI,       TAP_SEL_DR};
    tbl[TAP_SEL_IR]    = '{TAP_CAPT_IR,   TAP_TLR};
    tbl[TAP_CAPT_IR]   = '{TAP_SHIFT_IR,  TAP_EXIT1_IR};
    tbl[TAP_SHIFT_IR]  = '{TAP_SHIFT_IR,  TAP_EXIT1_IR};
    tbl[TAP_EXIT1_IR]  = '{TAP_PAUSE_IR,  TAP_UPDATE_IR};
    tbl[TAP_PAUSE_IR]  = '{TAP_PAUSE_IR,  TAP_EXIT2_IR};
    tbl[TAP_EXIT2_IR]  = '{TAP_SHIFT_IR,  TAP_UPDATE_IR};
    tbl[TAP_UPDATE_IR] = '{TAP_RTI,       TAP_SEL_DR};
  end

  // Model: shift paths as LSB-first bit queues.
  tap_state_t m_st;
  logic [IR_LENGTH-1:0] m_ir;
  bit irq[$];
  bit drq[$];

  task automatic model_step();
    bit t, d;
    t = tms;
    d = tdi;
    if (!reset_) begin
      m_st = TAP_TLR;
      m_ir = IDCODE;
      irq.delete();
      drq.delete();
      return;
    end
    case (m_st)
      TAP_CAPT_IR: begin
        irq.delete();
        irq.push_back(1'b1);
        for (int i = 1; i < IR_LENGTH; i++) irq.push_back(1'b0);
      end
      TAP_SHIFT_IR: begin
        void'(irq.pop_front());
        irq.push_back(d);
      end
      TAP_UPDATE_IR:
        for (int i = 0; i < IR_LENGTH; i++) m_ir[i] = irq[i];
      TAP_CAPT_DR: begin
        drq.delete();
        if (m_ir == IDCODE)
          for (int i = 0; i < 32; i++) drq.push_back(IDV[i]);
        else if (m_ir != EXTEST && m_ir != SCAN_N)
          drq.push_back(1'b0);
      end
      TAP_SHIFT_DR:
        if (drq.size() != 0) begin
          void'(drq.pop_front());
          drq.push_back(d);
        end
      default: ;
    endcase
    m_st = tbl[m_st][t];
    if (m_st == TAP_TLR) m_ir = IDCODE;
  endtask

  initial forever begin
    @(posedge tck);
    model_step();
  end

  initial forever begin
    bit e_oe, e_tdo;
    @(negedge tck);
    e_oe = (m_st == TAP_SHIFT_IR) || (m_st == TAP_SHIFT_DR);
    e_tdo = 1'b0;
    if (m_st == TAP_SHIFT_IR) e_tdo = irq[0];
    else if (m_st == TAP_SHIFT_DR)
      e_tdo = (drq.size() != 0) ? drq[0] : tdo_i;
    #1;
    if (chk_en) begin
      chk("tlr", 32'(test_logic_reset), 32'(m_st == TAP_TLR));
      chk("rti", 32'(run_test_idle), 32'(m_st == TAP_RTI));
      chk("capture_dr", 32'(capture_dr), 32'(m_st == TAP_CAPT_DR));
      chk("shift_dr", 32'(shift_dr), 32'(m_st == TAP_SHIFT_DR));
      chk("update_dr", 32'(update_dr), 32'(m_st == TAP_UPDATE_DR));
      chk("ir", 32'(ir), 32'(m_ir));
      chk("tdo_oe", 32'(tdo_oe), 32'(e_oe));
      chk("tdo", 32'(tdo), 32'(e_tdo));
      if (capture_dr) cnt_cap++;
      if (shift_dr) cnt_shift++;
      if (update_dr) cnt_upd++;
    end
  end

  task automatic tick(input bit t, input bit d = 1'b0, input bit r = 1'b0);
    tms = t;
    tdi = d;
    tdo_i = r;
    @(posedge tck);
    #2;
  endtask

  // Both scans start and end in Run-Test/Idle.
  task automatic dr_scan(input int n, input logic [31:0] din,
                         input logic [31:0] rin, output logic [31:0] dout);
    tick(1); tick(0); tick(0);
    dout = '0;
    for (int i = 0; i < n; i++) begin
      tick(i == n - 1, din[i], rin[i]);
      dout[i] = tdo;
    end
    tick(1); tick(0);
  endtask

  task automatic ir_scan(input int n, input logic [31:0] din,
                         output logic [31:0] dout);
    tick(1); tick(1); tick(0); tick(0);
    dout = '0;
    for (int i = 0; i < n; i++) begin
      tick(i == n - 1, din[i]);
      dout[i] = tdo;
    end
    tick(1); tick(0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    // Reset held two clocks
    tick(1);
    chk_en = 1;
    tick(1);
    reset_ = 1'b1;
    tms = 1'b0;
    chk("rst_tlr", 32'(test_logic_reset), 32'd1);
    chk("rst_ir", 32'(ir), 32'(IDCODE));
    chk("rst_oe", 32'(tdo_oe), 32'd0);
    chk("rst_tdo", 32'(tdo), 32'd0);
    tick(0);
    chk("rti_after_rst", 32'(run_test_idle), 32'd1);
    chk("tlr_after_rst", 32'(test_logic_reset), 32'd0);

    // Random TMS walks, each closed by five TMS=1 clocks
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < 60; k++)
        tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      for (int k = 0; k < 5; k++) tick(1);
      chk("walk_tlr", 32'(test_logic_reset), 32'd1);
      chk("walk_ir", 32'(ir), 32'(IDCODE));
    end
    tick(0);

    // IDCODE readout
    dr_scan(32, 32'hDEAD_BEEF, 32'h0, r);
    chk("idcode", r, 32'h1000_0001);

    // IR scan of all ones selects BYPASS
    ir_scan(4, 32'hF, r);
    chk("ir_capture", r, 32'h1);
    chk("ir_bypass", 32'(ir), 32'hF);
    dr_scan(8, 32'hA5, 32'h0, r);
    chk("bypass_a5", r, 32'h4A);

    // Over-long IR scan keeps last four bits: SCAN_N
    ir_scan(6, 32'h07, r);
    chk("ir_long_out", r, 32'h31);
    chk("ir_scan_n", 32'(ir), 32'(SCAN_N));
    cnt_cap = 0; cnt_shift = 0; cnt_upd = 0;
    dr_scan(4, 32'h0, 32'hA, r);
    chk("tdo_i_mirror", r, 32'hA);
    chk("cnt_capture", 32'(cnt_cap), 32'd1);
    chk("cnt_shift", 32'(cnt_shift), 32'd4);
    chk("cnt_update", 32'(cnt_upd), 32'd1);

    // Reset in the middle of Shift-IR
    cnt_upd = 0;
    tick(1); tick(1); tick(0); tick(0);
    tick(0, 0); tick(0, 0);
    reset_ = 1'b0;
    tick(0);
    @(negedge tck);
    #1;
    chk("midrst_tlr", 32'(test_logic_reset), 32'd1);
    chk("midrst_ir", 32'(ir), 32'(IDCODE));
    chk("midrst_oe", 32'(tdo_oe), 32'd0);
    chk("midrst_tdo", 32'(tdo), 32'd0);
    chk("midrst_no_upd", 32'(cnt_upd), 32'd0);
    reset_ = 1'b1;
    tick(0);
    tick(0);
    chk("post_rti", 32'(run_test_idle), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
